// File: rtl/prog_loader_if.sv
// Byte-stream input and memory write bus of the boot loader.
interface prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;

  // loader side: consumes bytes, drives the memory write port
  modport slave (
    input  in_valid, in_byte,
    output in_ready, mem_address, mem_data, mem_wren
  );

  // environment side: produces bytes, observes memory writes
  modport master (
    output in_valid, in_byte,
    input  in_ready, mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: assembles LE words from a byte stream, writes them from
// address 0, checks a mod-256 byte sum and releases the core on success.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_req,
  prog_loader_if.slave bus,
  output logic        busy,
  output logic        cpu_rst_n,
  output logic        cpu_start,
  output logic        done,
  output logic        err
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_BYTES = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CHK   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]        state;
  logic [7:0]        n_words;   // 0 encodes 256
  logic [ADDR_W-1:0] word_cnt;
  logic [1:0]        byte_cnt;
  logic [7:0]        sum;
  logic [DATA_W-1:0] word_buf;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              start_q;
  logic              acc;

  // status and handshake decode straight from the state
  always_comb begin
    bus.in_ready    = (state == S_HDR) || (state == S_BYTES) || (state == S_CHK);
    bus.mem_wren    = (state == S_WRITE);
    bus.mem_address = addr_q;
    bus.mem_data    = data_q;
    busy            = bus.in_ready || (state == S_WRITE);
    cpu_rst_n       = (state == S_IDLE) || (state == S_DONE);
    done            = (state == S_DONE);
    err             = (state == S_ERR);
    cpu_start       = start_q;
    acc             = bus.in_valid && bus.in_ready;
  end

  // load sequencer; write address/data are captured on the 4th byte so they
  // are valid during WRITE and hold afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      n_words  <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      sum      <= '0;
      word_buf <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      start_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (load_req) begin
            state    <= S_HDR;
            word_cnt <= '0;
            byte_cnt <= '0;
            sum      <= '0;
          end
        end
        S_HDR: begin
          if (acc) begin
            n_words <= bus.in_byte;
            state   <= S_BYTES;
          end
        end
        S_BYTES: begin
          if (acc) begin
            word_buf[{byte_cnt, 3'b000} +: 8] <= bus.in_byte;
            sum      <= sum + bus.in_byte;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              addr_q <= word_cnt;
              data_q <= {bus.in_byte, word_buf[23:0]};
              state  <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          word_cnt <= word_cnt + 1'b1;
          // last word when word_cnt == N-1; 8-bit wrap makes N=0 end at 255
          state    <= (word_cnt == ADDR_W'(n_words - 8'd1)) ? S_CHK : S_BYTES;
        end
        S_CHK: begin
          if (acc) begin
            if (bus.in_byte == sum) begin
              state   <= S_DONE;
              start_q <= 1'b1;
            end else begin
              state <= S_ERR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
